// File: rtl/serial_loader.sv
// Byte-stream program loader: length header, then LE words into imem.
// Holds the core in reset (o_done=0) until the whole image is written.
module serial_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  output logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] len_q, len_d;
  logic [31:0] idx_q, idx_d;
  logic        err_q, err_d;
  logic        arm_q;

  logic        accept;
  logic [31:0] shifted;
  logic [31:0] idx_inc;
  logic        in_range;

  assign shifted  = {i_data, word_q[31:8]};
  assign idx_inc  = idx_q + 32'd1;
  assign in_range = {1'b0, idx_q} < DEPTH;
  assign accept   = i_valid & i_ready;

  // i_ready only opens one edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) arm_q <= 1'b0;
    else     arm_q <= 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN;
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      len_q   <= 32'd0;
      idx_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state: byte assembly, header decode, word write sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      S_LEN: begin
        if (accept) begin
          word_d = shifted;
          cnt_d  = 2'(cnt_q + 2'd1);
          if (cnt_q == 2'd3) begin
            len_d = shifted;
            if ({1'b0, shifted} > DEPTH) err_d = 1'b1;
            if (shifted == 32'd0) state_d = S_DONE;
            else                  state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = shifted;
          cnt_d  = 2'(cnt_q + 2'd1);
          if (cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == len_q) state_d = S_DONE;
        else                  state_d = S_DATA;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
    endcase
  end

  // Outputs; out-of-range words are consumed but never strobed
  always_comb begin
    i_ready   = arm_q & ((state_q == S_LEN) | (state_q == S_DATA));
    mem_we    = (state_q == S_WRITE) & in_range;
    mem_addr  = idx_q[ADDR_WIDTH-1:0];
    mem_wdata = word_q;
    o_done    = (state_q == S_DONE);
    o_err     = err_q;
  end

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 10, meaning the word-address width of the target instruction memory (depth = 2**ADDR_WIDTH words).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port i_data, input, 8 bits: received byte from the serial_interface o_data output.
REQ-005 The module SHALL have port i_valid, input, 1 bit: i_data is valid.
REQ-006 The module SHALL have port i_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-007 The module SHALL have port mem_addr, output, ADDR_WIDTH bits: instruction-memory write address.
REQ-008 The module SHALL have port mem_wdata, output, 32 bits: instruction-memory write data.
REQ-009 The module SHALL have port mem_we, output, 1 bit: single-cycle write strobe.
REQ-010 The module SHALL have port o_done, output, 1 bit: load complete; drives the fcpu core out of reset.
REQ-011 The module SHALL have port o_err, output, 1 bit: sticky flag, the length header exceeded memory depth.

Function
REQ-012 A byte SHALL be transferred only on a rising edge where i_valid=1 and i_ready=1; i_valid low cycles SHALL insert gaps with no state change.
REQ-013 The FSM SHALL have states LEN, DATA, WRITE, DONE; the reset state SHALL be LEN.
REQ-014 In LEN, i_ready SHALL be 1; four accepted bytes SHALL form a 32-bit word count N, little-endian (first byte = bits 7:0).
REQ-015 After the 4th LEN byte: N=0 -> DONE; otherwise -> DATA; the byte counter SHALL return to 0.
REQ-016 In DATA, i_ready SHALL be 1; four accepted bytes SHALL form one little-endian 32-bit word in a shift register; after the 4th byte the state SHALL be WRITE.
REQ-017 In WRITE (exactly one cycle), i_ready SHALL be 0, mem_wdata SHALL hold the assembled word, mem_addr the current word index, and mem_we SHALL be 1 if the index < 2**ADDR_WIDTH, else 0.
REQ-018 Latency: mem_we SHALL assert on the cycle immediately after the edge accepting the 4th byte of a word.
REQ-019 Leaving WRITE, the 32-bit word index SHALL increment; if it then equals N, the next state SHALL be DONE, else DATA.
REQ-020 mem_addr SHALL be the low ADDR_WIDTH bits of the word index; words with index >= depth SHALL be consumed but never written (no wrap-around overwrite).
REQ-021 o_err SHALL set on the cycle after the 4th LEN byte if N > 2**ADDR_WIDTH and remain 1 until reset.
REQ-022 In DONE, o_done SHALL be 1, i_ready SHALL be 0, mem_we SHALL be 0, and the FSM SHALL remain in DONE until reset.
REQ-023 o_done SHALL first assert the cycle after the last WRITE cycle (or the cycle after the 4th LEN byte when N=0).
REQ-024 mem_we SHALL never be 1 in any state other than WRITE.

Reset
REQ-025 While rst=1, and immediately on its assertion irrespective of clk, outputs SHALL be: i_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, o_done=0, o_err=0; state=LEN, byte counter=0, word index=0, N=0.
REQ-026 Reset asserted mid-header or mid-word SHALL discard all partial bytes; the first byte after reset SHALL be treated as LEN byte 0.
REQ-027 i_ready SHALL go to 1 on the first rising edge after rst deasserts.

Verification
REQ-028 Bytes 02 00 00 00, 13 00 00 00, EF BE AD DE back-to-back -> mem_we pulses at addr 0 data 0x00000013 then addr 1 data 0xDEADBEEF, o_done=1 one cycle after the second pulse, o_err=0.
REQ-029 Bytes 00 00 00 00 -> no mem_we, o_done=1 one cycle after 4th byte, i_ready=0 thereafter.
REQ-030 ADDR_WIDTH=2, header 05 00 00 00, words 1..5 -> o_err=1 after header, mem_we for addrs 0..3 only, 5th word consumed without write, o_done=1.
REQ-031 Header 01 00 00 00 with random 0-5 cycle i_valid gaps between bytes -> single write identical to gap-free case; i_ready=0 only in WRITE and DONE.
REQ-032 rst pulsed after 2 bytes of a data word, then 01 00 00 00 AA BB CC DD -> one write addr 0 data 0xDDCCBBAA, o_done=1.
